// File: rtl/sobel_window_gen_if.sv
// rtl/sobel_window_gen_if.sv - pixel stream in / 3x3 window out bundle for sobel_window_gen
// Signals:
//   en, in_Pixel[23:0], in_valid, in_sof          pixel source -> window generator
//   out_M0/1/2[71:0], win_valid, win_x, win_y,
//   frame_done                                    window generator -> Sobel stage
// Modports: master = pixel source / window sink, slave = window generator.
interface sobel_window_gen_if #(
   parameter int CNT_W = 11
) ();
   logic             en;
   logic [23:0]      in_Pixel;
   logic             in_valid;
   logic             in_sof;
   logic [71:0]      out_M0;
   logic [71:0]      out_M1;
   logic [71:0]      out_M2;
   logic             win_valid;
   logic [CNT_W-1:0] win_x;
   logic [CNT_W-1:0] win_y;
   logic             frame_done;

   modport master (
      output en, in_Pixel, in_valid, in_sof,
      input  out_M0, out_M1, out_M2, win_valid, win_x, win_y, frame_done
   );

   modport slave (
      input  en, in_Pixel, in_valid, in_sof,
      output out_M0, out_M1, out_M2, win_valid, win_x, win_y, frame_done
   );
endinterface

// File: rtl/sobel_window_gen.sv
// rtl/sobel_window_gen.sv - raster pixel stream to 3x3 Sobel window with line buffers
// Ports:
//   clk    in  system clock, posedge
//   rst_n  in  synchronous active-low reset
//   s      sobel_window_gen_if.slave: en/in_Pixel/in_valid/in_sof in,
//          out_M0/1/2 rows {right,mid,left}, win_valid, win_x, win_y, frame_done out
module sobel_window_gen #(
   parameter int IMG_WIDTH  = 640,
   parameter int IMG_HEIGHT = 480,
   parameter int CNT_W      = 11
) (
   input  logic              clk,
   input  logic              rst_n,
   sobel_window_gen_if.slave s
);
   localparam int AW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
   localparam logic [CNT_W-1:0] COL_LAST = CNT_W'(IMG_WIDTH - 1);
   localparam logic [CNT_W-1:0] ROW_LAST = CNT_W'(IMG_HEIGHT - 1);
   localparam logic [CNT_W-1:0] TWO      = CNT_W'(2);

   typedef enum logic [1:0] {S_IDLE, S_FILL, S_RUN} state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] col_q, col_d, row_q, row_d;
   logic [CNT_W-1:0] pcol, prow;      // coordinate assigned to the accepted pixel
   logic             accept, take, win_d, done_d;
   logic [AW-1:0]    idx;

   // Line buffers: lb0 = previous line, lb1 = line before that. No reset;
   // stale contents never reach a valid window because the FSM only flags
   // windows once two fresh lines have been loaded.
   logic [23:0]      lb0 [IMG_WIDTH];
   logic [23:0]      lb1 [IMG_WIDTH];
   logic [23:0]      rd0, rd1;

   logic [71:0]      m0_q, m1_q, m2_q;
   logic             win_valid_q, frame_done_q;
   logic [CNT_W-1:0] win_x_q, win_y_q;

   assign idx = pcol[AW-1:0];
   assign rd0 = lb0[idx];
   assign rd1 = lb1[idx];

   always_comb begin
      accept  = s.en & s.in_valid;
      state_d = state_q;
      col_d   = col_q;
      row_d   = row_q;
      pcol    = col_q;
      prow    = row_q;
      take    = 1'b0;
      win_d   = 1'b0;
      done_d  = 1'b0;
      if (accept) begin
         if (s.in_sof) begin
            // sof always restarts the frame at (0,0), whatever state we were in
            take    = 1'b1;
            pcol    = '0;
            prow    = '0;
            state_d = S_FILL;
         end else if (state_q != S_IDLE) begin
            take = 1'b1;
         end
      end
      if (take) begin
         if (!s.in_sof && state_q == S_FILL && row_q == TWO) begin
            state_d = S_RUN;
         end
         win_d = (prow >= TWO) && (pcol >= TWO);
         if (!s.in_sof && state_q == S_RUN && pcol == COL_LAST && prow == ROW_LAST) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
            col_d   = '0;
            row_d   = '0;
         end else if (pcol == COL_LAST) begin
            col_d = '0;
            row_d = prow + 1'b1;
         end else begin
            col_d = pcol + 1'b1;
            row_d = prow;
         end
      end
   end

   // Read-before-write: the old lb0 entry moves down to lb1 as the new pixel lands.
   always_ff @(posedge clk) begin
      if (rst_n && take) begin
         lb0[idx] <= s.in_Pixel;
         lb1[idx] <= rd0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         col_q        <= '0;
         row_q        <= '0;
         m0_q         <= '0;
         m1_q         <= '0;
         m2_q         <= '0;
         win_valid_q  <= 1'b0;
         frame_done_q <= 1'b0;
         win_x_q      <= '0;
         win_y_q      <= '0;
      end else begin
         state_q      <= state_d;
         col_q        <= col_d;
         row_q        <= row_d;
         win_valid_q  <= win_d;
         frame_done_q <= done_d;
         if (take) begin
            // New column enters at the right (top 24 bits); left column falls off.
            m0_q <= {rd1,        m0_q[71:24]};
            m1_q <= {rd0,        m1_q[71:24]};
            m2_q <= {s.in_Pixel, m2_q[71:24]};
         end
         if (win_d) begin
            win_x_q <= pcol - 1'b1;
            win_y_q <= prow - 1'b1;
         end
      end
   end

   assign s.out_M0     = m0_q;
   assign s.out_M1     = m1_q;
   assign s.out_M2     = m2_q;
   assign s.win_valid  = win_valid_q;
   assign s.win_x      = win_x_q;
   assign s.win_y      = win_y_q;
   assign s.frame_done = frame_done_q;
endmodule

// File: tb/tb_sobel_window_gen.sv
// tb/tb_sobel_window_gen.sv - scoreboard bench for sobel_window_gen on a 4x4 image
module tb_sobel_window_gen;
   localparam int W  = 4;
   localparam int H  = 4;
   localparam int CW = 11;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   sobel_window_gen_if #(.CNT_W(CW)) bus ();

   sobel_window_gen #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .CNT_W(CW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .s     (bus.slave)
   );

   typedef struct {
      int          x;
      int          y;
      logic [71:0] m0;
      logic [71:0] m1;
      logic [71:0] m2;
   } win_t;

   win_t        exp_q[$];
   win_t        mon_e;
   int          n_cmp = 0;
   int          n_bad = 0;
   int          fd_pend = 0;
   int          strobes = 0;
   int          fds = 0;
   logic [23:0] img [H][W];
   bit          m_active = 0;
   int          mc = 0;
   int          mr = 0;
   logic        acc_q = 1'b0;
   bit          cap_first = 0;
   logic [71:0] f_m0, f_m1, f_m2;

   task automatic check(string name, logic [71:0] act, logic [71:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference: place each accepted pixel into an image array by raster
   // position; a window is due whenever a full 3x3 block ending at that pixel exists.
   task automatic model_accept(bit sof, logic [23:0] pix);
      win_t w;
      if (sof) begin
         m_active = 1;
         mc = 0;
         mr = 0;
      end else if (!m_active) begin
         return;
      end
      img[mr][mc] = pix;
      if (mr >= 2 && mc >= 2) begin
         w.x  = mc - 1;
         w.y  = mr - 1;
         w.m0 = {img[mr-2][mc], img[mr-2][mc-1], img[mr-2][mc-2]};
         w.m1 = {img[mr-1][mc], img[mr-1][mc-1], img[mr-1][mc-2]};
         w.m2 = {img[mr][mc],   img[mr][mc-1],   img[mr][mc-2]};
         exp_q.push_back(w);
      end
      if (mc == W-1 && mr == H-1) begin
         fd_pend++;
         m_active = 0;
         mc = 0;
         mr = 0;
      end else if (mc == W-1) begin
         mc = 0;
         mr++;
      end else begin
         mc++;
      end
   endtask

   task automatic step(bit e, bit v, bit sof, logic [23:0] pix);
      @(posedge clk);
      #1;
      bus.en       = e;
      bus.in_valid = v;
      bus.in_sof   = sof;
      bus.in_Pixel = pix;
      if (e && v) model_accept(sof, pix);
   endtask

   task automatic idle(int n);
      repeat (n) step(0, 0, 0, 24'h0);
   endtask

   task automatic send(bit sof, logic [23:0] pix, bit gaps);
      if (gaps) begin
         repeat ($urandom_range(0, 2)) begin
            case ($urandom_range(0, 2))
               0:       step(0, 1, 1'($urandom), 24'($urandom));
               1:       step(1, 0, 1'($urandom), 24'($urandom));
               default: step(0, 0, 1'($urandom), 24'($urandom));
            endcase
         end
      end
      step(1, 1, sof, pix);
   endtask

   function automatic logic [23:0] pat(int r, int c, bit rnd);
      logic [23:0] p;
      p = rnd ? 24'($urandom) : 24'(16 * r + c);
      return p;
   endfunction

   task automatic frame(bit gaps, bit rnd);
      for (int r = 0; r < H; r++)
         for (int c = 0; c < W; c++)
            send(r == 0 && c == 0, pat(r, c, rnd), gaps);
   endtask

   always @(posedge clk) acc_q <= rst_n & bus.en & bus.in_valid;

   always @(negedge clk) begin
      if (bus.win_valid === 1'b1) begin
         strobes++;
         check("win_after_accept", 72'(acc_q), 72'(1));
         if (cap_first) begin
            f_m0 = bus.out_M0;
            f_m1 = bus.out_M1;
            f_m2 = bus.out_M2;
            cap_first = 0;
         end
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_window: got win_valid=1 expected none (x=%0d y=%0d)", bus.win_x, bus.win_y);
         end else begin
            mon_e = exp_q.pop_front();
            check("win_x", 72'(bus.win_x), 72'(mon_e.x));
            check("win_y", 72'(bus.win_y), 72'(mon_e.y));
            check("out_M0", bus.out_M0, mon_e.m0);
            check("out_M1", bus.out_M1, mon_e.m1);
            check("out_M2", bus.out_M2, mon_e.m2);
         end
      end
      if (bus.frame_done === 1'b1) begin
         fds++;
         check("frame_done_after_accept", 72'(acc_q), 72'(1));
         n_cmp++;
         if (fd_pend > 0) begin
            fd_pend--;
         end else begin
            n_bad++;
            $display("FAIL unexpected_frame_done: got pulse expected none");
         end
      end
   end

   task automatic check_zero(string tag);
      check({tag, "_M0"}, bus.out_M0, 72'h0);
      check({tag, "_M1"}, bus.out_M1, 72'h0);
      check({tag, "_M2"}, bus.out_M2, 72'h0);
      check({tag, "_win_valid"}, 72'(bus.win_valid), 72'h0);
      check({tag, "_win_x"}, 72'(bus.win_x), 72'h0);
      check({tag, "_win_y"}, 72'(bus.win_y), 72'h0);
      check({tag, "_frame_done"}, 72'(bus.frame_done), 72'h0);
   endtask

   task automatic check_first(string tag);
      check({tag, "_first_M0"}, f_m0, 72'h000002_000001_000000);
      check({tag, "_first_M1"}, f_m1, 72'h000012_000011_000010);
      check({tag, "_first_M2"}, f_m2, 72'h000022_000021_000020);
   endtask

   int s0, f0;

   initial begin
      bus.en = 0;
      bus.in_valid = 0;
      bus.in_sof = 0;
      bus.in_Pixel = '0;
      f_m0 = '1;
      f_m1 = '1;
      f_m2 = '1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_zero("reset");
      #1 rst_n = 1;

      // plain frame, B = 16*row+col
      s0 = strobes; f0 = fds; cap_first = 1;
      frame(0, 0);
      idle(3);
      check("t1_strobes", 72'(strobes - s0), 72'(4));
      check("t1_frame_done", 72'(fds - f0), 72'(1));
      check_first("t1");

      // random pixels with stalls
      s0 = strobes; f0 = fds;
      frame(1, 1);
      idle(3);
      check("t2_strobes", 72'(strobes - s0), 72'(4));
      check("t2_frame_done", 72'(fds - f0), 72'(1));

      // sof re-asserted at (1,2): partial frame discarded
      s0 = strobes; f0 = fds;
      for (int i = 0; i < 2 * W + 1; i++) send(i == 0, 24'($urandom), 1);
      frame(1, 1);
      idle(3);
      check("t3_strobes", 72'(strobes - s0), 72'(4));
      check("t3_frame_done", 72'(fds - f0), 72'(1));

      // reset mid-frame, then pixels without sof are dropped
      for (int i = 0; i < 6; i++) send(i == 0, 24'($urandom), 0);
      @(posedge clk);
      #1;
      rst_n = 0;
      bus.en = 0;
      bus.in_valid = 0;
      @(posedge clk);
      #1 rst_n = 1;
      m_active = 0;
      mc = 0;
      mr = 0;
      @(negedge clk);
      check_zero("midreset");
      s0 = strobes; f0 = fds; cap_first = 1;
      for (int i = 0; i < 3 * W; i++) send(0, 24'($urandom), 1);
      idle(2);
      check("t4_dropped_strobes", 72'(strobes - s0), 72'(0));
      frame(0, 0);
      idle(3);
      check("t4_strobes", 72'(strobes - s0), 72'(4));
      check("t4_frame_done", 72'(fds - f0), 72'(1));
      check_first("t4");

      // back-to-back frames
      s0 = strobes; f0 = fds;
      frame(0, 1);
      frame(0, 1);
      idle(3);
      check("t5_strobes", 72'(strobes - s0), 72'(8));
      check("t5_frame_done", 72'(fds - f0), 72'(2));

      check("leftover_windows", 72'(exp_q.size()), 72'(0));
      check("leftover_frame_done", 72'(fd_pend), 72'(0));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
